// File: rtl/ddsfg_pkg.sv
// Shared defaults and encodings for the DDS function generator rate control.
// Holds the default divisor table (entry k at bits [k*CNT_W +: CNT_W]) and the direction encoding.
package ddsfg_pkg;

  localparam int NUM_MODES_DEF = 5;
  localparam int MODE_W_DEF    = 3;
  localparam int CNT_W_DEF     = 15;

  localparam logic [NUM_MODES_DEF*CNT_W_DEF-1:0] DIV_TABLE_DEF =
    {15'd10000, 15'd1000, 15'd100, 15'd10, 15'd0};

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  typedef struct packed {
    logic vld;
    dir_e dir;
  } pend_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability filter, one-cycle rise pulse.
// Pin-to-pulse latency is 2+DEB_CYCLES cycles; there is no backpressure.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic rise
);

  localparam int SW = $clog2(DEB_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [SW-1:0] stab;

  // stab counts consecutive synchronised samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync  <= '0;
      level <= 1'b0;
      stab  <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      rise <= 1'b0;
      if (sync[1] == level) begin
        stab <= '0;
      end else if (stab == STAB_LAST) begin
        level <= sync[1];
        stab  <= '0;
        rise  <= sync[1];
      end else begin
        stab <= stab + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sampling_rate_ctrl.sv
// Sample-rate controller: start-up Ready pulse, table-driven Enable divider, button-stepped Mode.
// Enable period is D+1 cycles; Hold freezes the divider, and queued mode steps apply on the next Enable.
module sampling_rate_ctrl
  import ddsfg_pkg::*;
#(
  parameter int NUM_MODES  = NUM_MODES_DEF,
  parameter int MODE_W     = MODE_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter logic [NUM_MODES*CNT_W-1:0] DIV_TABLE = DIV_TABLE_DEF,
  parameter int INIT_MODE  = 0,
  parameter int READY_DLY  = 78,
  parameter int DEB_CYCLES = 4
) (
  input  logic              Fg_clk,
  input  logic              Resetn,
  input  logic              BtnUp,
  input  logic              BtnDown,
  input  logic              Hold,
  output logic              Ready,
  output logic              Enable,
  output logic [MODE_W-1:0] Mode,
  output logic              ModeChg
);

  if (NUM_MODES < 2 || (1 << MODE_W) < NUM_MODES || INIT_MODE >= NUM_MODES ||
      READY_DLY >= 254 || DEB_CYCLES < 1) begin : g_param_err
    $error("sampling_rate_ctrl: illegal parameter set");
  end

  localparam logic [7:0] RDY_LAST = 8'(READY_DLY);
  localparam logic [7:0] RDY_SAT  = 8'(READY_DLY + 1);

  logic [7:0]       rcount;
  logic             armed;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] div_tab [NUM_MODES];
  logic             req_up;
  logic             req_dn;
  logic             apply;
  pend_t            pend;

  for (genvar k = 0; k < NUM_MODES; k++) begin : g_tab
    assign div_tab[k] = DIV_TABLE[k*CNT_W +: CNT_W];
  end

  assign div_d = div_tab[Mode];
  assign apply = Enable & pend.vld;

  function automatic logic [MODE_W-1:0] step_mode(input logic [MODE_W-1:0] m, input dir_e dir);
    logic [MODE_W-1:0] last;
    last = MODE_W'(NUM_MODES - 1);
    if (dir == DIR_UP) step_mode = (m == last) ? '0 : m + 1'b1;
    else               step_mode = (m == '0) ? last : m - 1'b1;
  endfunction

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk    (Fg_clk),
    .resetn (Resetn),
    .pin    (BtnUp),
    .rise   (req_up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk    (Fg_clk),
    .resetn (Resetn),
    .pin    (BtnDown),
    .rise   (req_dn)
  );

  // rcount saturates one past READY_DLY, so the Ready compare can only hit once per reset
  always_ff @(posedge Fg_clk) begin
    if (!Resetn) begin
      rcount <= '0;
      Ready  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      Ready <= (rcount == RDY_LAST);
      if (rcount != RDY_SAT) rcount <= rcount + 1'b1;
      if (rcount == RDY_LAST) armed <= 1'b1;
    end
  end

  always_ff @(posedge Fg_clk) begin
    if (!Resetn) begin
      count   <= '0;
      Enable  <= 1'b0;
      Mode    <= MODE_W'(INIT_MODE);
      ModeChg <= 1'b0;
      pend    <= '0;
    end else begin
      ModeChg <= 1'b0;
      // a mode step restarts the divider so the new period is measured from the change
      if (apply) begin
        Mode    <= step_mode(Mode, pend.dir);
        ModeChg <= 1'b1;
        count   <= '0;
        Enable  <= 1'b0;
      end else if (!armed || Hold) begin
        Enable <= 1'b0;
      end else if (div_d == '0) begin
        Enable <= 1'b1;
      end else if (count == div_d) begin
        count  <= '0;
        Enable <= 1'b1;
      end else begin
        count  <= count + 1'b1;
        Enable <= 1'b0;
      end

      // simultaneous up and down requests cancel; a fresh request outlives a same-cycle apply
      if (req_up ^ req_dn) begin
        pend.vld <= 1'b1;
        pend.dir <= req_up ? DIR_UP : DIR_DN;
      end else if (apply) begin
        pend.vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sampling_rate_ctrl.sv
// Bench for sampling_rate_ctrl: vector tables, hand sequences and random stimulus
// checked every cycle against an arithmetic reference model.
module tb_sampling_rate_ctrl;

  localparam int RDY = 78;
  localparam int DEB = 4;
  localparam int NM  = 5;

  logic       Fg_clk  = 1'b0;
  logic       Resetn  = 1'b0;
  logic       BtnUp   = 1'b0;
  logic       BtnDown = 1'b0;
  logic       Hold    = 1'b0;
  logic       Ready;
  logic       Enable;
  logic [2:0] Mode;
  logic       ModeChg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 Fg_clk = ~Fg_clk;

  sampling_rate_ctrl dut (
    .Fg_clk  (Fg_clk),
    .Resetn  (Resetn),
    .BtnUp   (BtnUp),
    .BtnDown (BtnDown),
    .Hold    (Hold),
    .Ready   (Ready),
    .Enable  (Enable),
    .Mode    (Mode),
    .ModeChg (ModeChg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_of(input int m);
    case (m)
      0: return 0;
      1: return 10;
      2: return 100;
      3: return 1000;
      default: return 10000;
    endcase
  endfunction

  // Reference model: Ready from an edge count since release, Enable from the number of
  // active (armed, unheld) edges since the last restart taken modulo D+1, buttons from
  // a sliding window over the pin history delayed by the two synchroniser stages.
  int             m_edges = 0;
  int             m_mode  = 0;
  int             m_n     = 0;
  bit             m_ready = 0, m_en = 0, m_chg = 0, m_pvld = 0, m_pdir = 0;
  bit [DEB+1:0]   up_h = '0, dn_h = '0;
  bit             up_lvl = 0, dn_lvl = 0, up_rq = 0, dn_rq = 0;

  always @(posedge Fg_clk) begin : model
    bit          armed_m, apply_m;
    bit [DEB-1:0] w;
    cyc++;
    if (!Resetn) begin
      m_edges = 0; m_mode = 0; m_n = 0;
      m_ready = 0; m_en = 0; m_chg = 0; m_pvld = 0; m_pdir = 0;
      up_h = '0; dn_h = '0; up_lvl = 0; dn_lvl = 0; up_rq = 0; dn_rq = 0;
    end else begin
      armed_m = (m_edges >= RDY + 1);
      if (m_edges < 100000) m_edges++;
      m_ready = (m_edges == RDY + 1);
      apply_m = m_en && m_pvld;
      if (apply_m) begin
        m_mode = m_pdir ? (m_mode + 1) % NM : (m_mode + NM - 1) % NM;
        m_chg = 1; m_n = 0; m_en = 0;
      end else begin
        m_chg = 0;
        if (!armed_m || Hold) m_en = 0;
        else begin
          m_n++;
          m_en = (m_n % (div_of(m_mode) + 1)) == 0;
        end
      end
      if (up_rq ^ dn_rq) begin m_pvld = 1; m_pdir = up_rq; end
      else if (apply_m) m_pvld = 0;
      up_h = {up_h[DEB:0], BtnUp};
      dn_h = {dn_h[DEB:0], BtnDown};
      up_rq = 0; dn_rq = 0;
      w = up_h[DEB+1:2];
      if (!up_lvl && w == {DEB{1'b1}}) begin up_lvl = 1; up_rq = 1; end
      else if (up_lvl && w == {DEB{1'b0}}) up_lvl = 0;
      w = dn_h[DEB+1:2];
      if (!dn_lvl && w == {DEB{1'b1}}) begin dn_lvl = 1; dn_rq = 1; end
      else if (dn_lvl && w == {DEB{1'b0}}) dn_lvl = 0;
    end
  end

  always @(negedge Fg_clk) begin
    if (cyc > 0) begin
      check("model_ready",   Ready,   m_ready);
      check("model_enable",  Enable,  m_en);
      check("model_mode",    Mode,    m_mode);
      check("model_modechg", ModeChg, m_chg);
    end
  end

  typedef struct {
    int cyc;
    bit rdy;
    bit en;
  } rdy_vec_t;

  typedef struct {
    int us, ul, ds, dl;
    int exp_mode;
    int exp_chg;
    int exp_gap;
  } rec_t;

  rdy_vec_t rv[6];
  rec_t     rt[13];

  task automatic ready_table();
    int idx = 0;
    Resetn = 1'b1;
    for (int k = 1; k <= 81; k++) begin
      @(negedge Fg_clk);
      if (idx < 6 && k == rv[idx].cyc) begin
        check("tbl_ready",  Ready,  rv[idx].rdy);
        check("tbl_enable", Enable, rv[idx].en);
        idx++;
      end
    end
  endtask

  task automatic wait_enable();
    int k = 0;
    while (!Enable && k < 21000) begin
      @(negedge Fg_clk);
      k++;
    end
    check("sync_enable", Enable, 1);
  endtask

  task automatic run_rec(input rec_t r);
    int  t = 0, nchg = 0, t0 = 0, gap = -1, pin_end;
    bit  done = 0, pe;
    pin_end = (r.us + r.ul > r.ds + r.dl) ? r.us + r.ul : r.ds + r.dl;
    wait_enable();
    while (!done) begin
      BtnUp   = (t >= r.us && t < r.us + r.ul);
      BtnDown = (t >= r.ds && t < r.ds + r.dl);
      pe = Enable;
      @(negedge Fg_clk);
      t++;
      if (ModeChg) begin
        check("chg_aligned", pe, 1);
        nchg++; t0 = t; gap = -1;
      end else if (nchg > 0 && gap < 0 && Enable) begin
        gap = t - t0;
      end
      if (t >= pin_end + 30 && (r.exp_chg == 0 || (nchg > 0 && gap >= 0))) done = 1;
      if (t >= 21000) done = 1;
    end
    BtnUp = 1'b0;
    BtnDown = 1'b0;
    check("rec_nchg", nchg, r.exp_chg);
    check("rec_mode", Mode, r.exp_mode);
    if (r.exp_chg != 0) check("rec_gap", gap, r.exp_gap);
  endtask

  task automatic hold_seq();
    int found = -1;
    wait_enable();
    for (int t = 1; t <= 40 && found < 0; t++) begin
      @(negedge Fg_clk);
      if (t >= 4 && t <= 8) check("hold_enable", Enable, 0);
      else if (Enable) found = t;
      if (t == 3) Hold = 1'b1;
      if (t == 8) Hold = 1'b0;
    end
    check("hold_gap", found, 16);
  endtask

  initial begin
    rv[0] = '{1, 0, 0};
    rv[1] = '{40, 0, 0};
    rv[2] = '{78, 0, 0};
    rv[3] = '{79, 1, 0};
    rv[4] = '{80, 0, 1};
    rv[5] = '{81, 0, 1};

    rt[0]  = '{0, 2,  0, 0,  0, 0, 0};
    rt[1]  = '{0, 10, 0, 0,  1, 1, 11};
    rt[2]  = '{0, 0,  0, 10, 0, 1, 1};
    rt[3]  = '{0, 10, 0, 10, 0, 0, 0};
    rt[4]  = '{0, 10, 0, 0,  1, 1, 11};
    rt[5]  = '{0, 10, 0, 0,  2, 1, 101};
    rt[6]  = '{0, 10, 12, 10, 1, 1, 11};
    rt[7]  = '{0, 10, 0, 0,  2, 1, 101};
    rt[8]  = '{0, 10, 0, 0,  3, 1, 1001};
    rt[9]  = '{0, 10, 0, 0,  4, 1, 10001};
    rt[10] = '{0, 10, 0, 0,  0, 1, 1};
    rt[11] = '{0, 0,  0, 10, 4, 1, 10001};
    rt[12] = '{0, 0,  0, 10, 3, 1, 1001};

    Resetn = 1'b0;
    repeat (3) @(negedge Fg_clk);
    check("rst_ready",   Ready,   0);
    check("rst_enable",  Enable,  0);
    check("rst_mode",    Mode,    0);
    check("rst_modechg", ModeChg, 0);

    ready_table();

    for (int i = 0; i < 13; i++) begin
      run_rec(rt[i]);
      if (i == 1) hold_seq();
    end

    repeat (5) @(negedge Fg_clk);
    check("pre_reset_mode", Mode, 3);
    Resetn = 1'b0;
    @(negedge Fg_clk);
    check("midrst_ready",   Ready,   0);
    check("midrst_enable",  Enable,  0);
    check("midrst_mode",    Mode,    0);
    check("midrst_modechg", ModeChg, 0);
    ready_table();

    for (int k = 0; k < 4000; k++) begin
      @(negedge Fg_clk);
      Hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) BtnUp = ~BtnUp;
      if ($urandom_range(0, 15) == 0) BtnDown = ~BtnDown;
      Resetn = ($urandom_range(0, 1999) != 0);
    end
    @(negedge Fg_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
